// File: rtl/overlay_pkg.sv
// rtl/overlay_pkg.sv - shared widths, RGB slot positions, mode and region encodings
package overlay_pkg;

    localparam int unsigned CH_W  = 4;
    localparam int unsigned RGB_W = 3 * CH_W;

    // Channel slot positions inside a packed {R,G,B} word, in units of channel width
    localparam int unsigned R_SLOT = 2;
    localparam int unsigned G_SLOT = 1;
    localparam int unsigned B_SLOT = 0;

    typedef enum logic [1:0] {
        MODE_OPAQUE     = 2'd0,
        MODE_AVG        = 2'd1,
        MODE_KEY        = 2'd2,
        MODE_OPAQUE_ALT = 2'd3
    } mode_e;

    localparam int unsigned REGION_LIVE = 0;

endpackage

// File: rtl/overlay_palette.sv
// rtl/overlay_palette.sv - double-buffered overlay palette with frame-aligned commit
module overlay_palette
    import overlay_pkg::*;
#(
    parameter int unsigned COLOR_W     = CH_W,
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned SEL_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 pal_wr_en,
    input  logic [SEL_W-1:0]     pal_wr_addr,
    input  logic [3*COLOR_W-1:0] pal_wr_data,
    input  logic                 pal_commit,
    input  logic [SEL_W-1:0]     rd_addr,
    output logic [3*COLOR_W-1:0] rd_data,
    output logic                 commit_pending
);

    // Entry k (region code k) lives at index k-1
    logic [3*COLOR_W-1:0] shadow_q [NUM_REGIONS];
    logic [3*COLOR_W-1:0] active_q [NUM_REGIONS];
    logic                 pending_q;
    logic                 pending_d;
    logic                 do_commit;

    assign do_commit = frame_start & (pending_q | pal_commit);

    always_comb begin
        pending_d = pending_q;
        if (do_commit) begin
            pending_d = 1'b0;
        end else if (pal_commit) begin
            pending_d = 1'b1;
        end
    end

    // active loads the pre-edge shadow, so a same-cycle write waits for the next commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            for (int k = 0; k < NUM_REGIONS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            for (int k = 0; k < NUM_REGIONS; k++) begin
                if (do_commit) begin
                    active_q[k] <= shadow_q[k];
                end
                if (pal_wr_en && pal_wr_addr == SEL_W'(k + 1)) begin
                    shadow_q[k] <= pal_wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if (rd_addr == SEL_W'(k + 1)) begin
                rd_data = active_q[k];
            end
        end
    end

    assign commit_pending = pending_q;

endmodule

// File: rtl/overlay_colorizer.sv
// rtl/overlay_colorizer.sv - 2-stage pixel pipeline selecting black, live feed or blended overlay
module overlay_colorizer
    import overlay_pkg::*;
#(
    parameter int unsigned          COLOR_W     = CH_W,
    parameter int unsigned          NUM_REGIONS = 4,
    parameter int unsigned          SEL_W       = 3,
    parameter logic [3*COLOR_W-1:0] KEY_COLOR   = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 video_on,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 frame_start,
    input  logic [3*COLOR_W-1:0] live_pixel,
    input  logic                 blank_disp,
    input  logic [SEL_W-1:0]     region_sel,
    input  logic [1:0]           mode,
    input  logic                 pal_wr_en,
    input  logic [SEL_W-1:0]     pal_wr_addr,
    input  logic [3*COLOR_W-1:0] pal_wr_data,
    input  logic                 pal_commit,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 commit_pending
);

    logic [3*COLOR_W-1:0] pal_rd;
    logic                 use_pal;

    // Stage 1 registers
    logic                 vo_q, hs1_q, vs1_q, blank_q, use_pal_q;
    logic [3*COLOR_W-1:0] live_q, pal_q;
    mode_e                mode_q;

    // Stage 2 registers
    logic [3*COLOR_W-1:0] rgb_q, rgb_d, avg;
    logic                 hs2_q, vs2_q;

    overlay_palette #(
        .COLOR_W     (COLOR_W),
        .NUM_REGIONS (NUM_REGIONS),
        .SEL_W       (SEL_W)
    ) u_palette (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_start    (frame_start),
        .pal_wr_en      (pal_wr_en),
        .pal_wr_addr    (pal_wr_addr),
        .pal_wr_data    (pal_wr_data),
        .pal_commit     (pal_commit),
        .rd_addr        (region_sel),
        .rd_data        (pal_rd),
        .commit_pending (commit_pending)
    );

    // Codes 0 and above NUM_REGIONS both fall back to the live feed
    assign use_pal = (region_sel != SEL_W'(REGION_LIVE)) && (region_sel <= SEL_W'(NUM_REGIONS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vo_q      <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            blank_q   <= 1'b0;
            use_pal_q <= 1'b0;
            live_q    <= '0;
            pal_q     <= '0;
            mode_q    <= MODE_OPAQUE;
        end else begin
            vo_q      <= video_on;
            hs1_q     <= hsync_in;
            vs1_q     <= vsync_in;
            blank_q   <= blank_disp;
            use_pal_q <= use_pal;
            live_q    <= live_pixel;
            pal_q     <= pal_rd;
            mode_q    <= mode_e'(mode);
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_avg
        logic [COLOR_W:0] sum;
        assign sum = {1'b0, pal_q[c*COLOR_W +: COLOR_W]} + {1'b0, live_q[c*COLOR_W +: COLOR_W]};
        assign avg[c*COLOR_W +: COLOR_W] = sum[COLOR_W:1];
    end

    always_comb begin
        rgb_d = live_q;
        if (!vo_q || blank_q) begin
            rgb_d = '0;
        end else if (use_pal_q) begin
            case (mode_q)
                MODE_AVG: rgb_d = avg;
                MODE_KEY: rgb_d = (pal_q == KEY_COLOR) ? live_q : pal_q;
                default:  rgb_d = pal_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign red       = rgb_q[R_SLOT*COLOR_W +: COLOR_W];
    assign green     = rgb_q[G_SLOT*COLOR_W +: COLOR_W];
    assign blue      = rgb_q[B_SLOT*COLOR_W +: COLOR_W];
    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;

endmodule

// File: tb/tb_overlay_colorizer.sv
// tb/tb_overlay_colorizer.sv - scoreboard bench for overlay_colorizer with a reference palette model
module tb_overlay_colorizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        video_on, hsync_in, vsync_in, frame_start, blank_disp;
    logic [11:0] live_pixel, pal_wr_data;
    logic [2:0]  region_sel, pal_wr_addr;
    logic [1:0]  mode;
    logic        pal_wr_en, pal_commit;
    logic [3:0]  red, green, blue;
    logic        hsync_out, vsync_out, commit_pending;

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t        sbq[$];
    logic [11:0] m_shadow [0:7];
    logic [11:0] m_active [0:7];
    logic        m_pend;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    overlay_colorizer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .video_on       (video_on),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .frame_start    (frame_start),
        .live_pixel     (live_pixel),
        .blank_disp     (blank_disp),
        .region_sel     (region_sel),
        .mode           (mode),
        .pal_wr_en      (pal_wr_en),
        .pal_wr_addr    (pal_wr_addr),
        .pal_wr_data    (pal_wr_data),
        .pal_commit     (pal_commit),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .commit_pending (commit_pending)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_pix();
        logic [11:0] p, l;
        logic [4:0]  s;
        logic [11:0] r;
        if (!video_on || blank_disp) return 12'h000;
        if (region_sel == 3'd0 || region_sel > 3'd4) return live_pixel;
        p = m_active[region_sel];
        l = live_pixel;
        if (mode == 2'd1) begin
            r = '0;
            for (int c = 0; c < 3; c++) begin
                s = 5'((p >> (4*c)) & 12'hF) + 5'((l >> (4*c)) & 12'hF);
                r = r | (12'(s >> 1) << (4*c));
            end
            return r;
        end
        if (mode == 2'd2) return (p == 12'h000) ? l : p;
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 12'h000;
            m_active[i] = 12'h000;
        end
        m_pend = 1'b0;
        sbq.delete();
    endtask

    task automatic idle_inputs();
        video_on = 0; hsync_in = 0; vsync_in = 0; frame_start = 0; blank_disp = 0;
        live_pixel = 0; region_sel = 0; mode = 0;
        pal_wr_en = 0; pal_wr_addr = 0; pal_wr_data = 0; pal_commit = 0;
    endtask

    // Called at a negedge with this cycle's inputs already set; returns at the next negedge
    task automatic step();
        exp_t e;
        if (sbq.size() == 2) begin
            e = sbq.pop_front();
            check_eq("rgb", {red, green, blue}, e.rgb);
            check_eq("hsync_out", hsync_out, e.hs);
            check_eq("vsync_out", vsync_out, e.vs);
        end
        e.rgb = model_pix();
        e.hs  = hsync_in;
        e.vs  = vsync_in;
        sbq.push_back(e);
        @(posedge clk);
        if (frame_start && (m_pend || pal_commit)) begin
            for (int i = 1; i <= 4; i++) m_active[i] = m_shadow[i];
            m_pend = 1'b0;
        end else if (pal_commit) begin
            m_pend = 1'b1;
        end
        if (pal_wr_en && pal_wr_addr >= 3'd1 && pal_wr_addr <= 3'd4) m_shadow[pal_wr_addr] = pal_wr_data;
        @(negedge clk);
        check_eq("commit_pending", commit_pending, m_pend);
        pal_wr_en = 0; pal_commit = 0; frame_start = 0;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [11:0] d);
        pal_wr_en = 1; pal_wr_addr = a; pal_wr_data = d;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            hsync_in = ~hsync_in;
            if (i % 3 == 0) vsync_in = ~vsync_in;
            step();
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_rgb", {red, green, blue}, 12'h000);
        check_eq("reset_sync", {hsync_out, vsync_out}, 2'b00);
        check_eq("reset_pend", commit_pending, 1'b0);
        rst_n = 1;

        // Live pass-through and sync delay
        video_on = 1; region_sel = 0; live_pixel = 12'hA5C;
        step();
        for (int i = 0; i < 6; i++) begin
            live_pixel = 12'($urandom);
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            step();
        end

        // Write and commit before frame_start: active stays black
        write_entry(3'd2, 12'hF00); pal_commit = 1;
        step();
        region_sel = 2;
        run(4);
        pal_commit = 1;
        run(2);
        frame_start = 1;
        run(4);
        frame_start = 1;
        run(3);

        // Average mode
        write_entry(3'd1, 12'hF0F);
        step();
        pal_commit = 1; frame_start = 1;
        step();
        mode = 1; region_sel = 1; live_pixel = 12'h0F2;
        run(4);

        // Colour key
        mode = 2; region_sel = 3; live_pixel = 12'h123;
        run(3);
        write_entry(3'd3, 12'h001);
        step();
        pal_commit = 1;
        step();
        frame_start = 1;
        run(4);

        // Same-cycle write/commit/frame_start
        mode = 0; region_sel = 1;
        write_entry(3'd1, 12'h00F);
        step();
        write_entry(3'd1, 12'h0F0); pal_commit = 1; frame_start = 1;
        run(4);
        pal_commit = 1; frame_start = 1;
        run(4);

        // Ignored addresses, blanking and out-of-range regions
        write_entry(3'd0, 12'hABC); step();
        write_entry(3'd5, 12'hDEF); pal_commit = 1; frame_start = 1; step();
        live_pixel = 12'h9E7;
        for (int s = 0; s < 8; s++) begin
            region_sel = 3'(s);
            blank_disp = 1; step();
            blank_disp = 0; video_on = 0; step();
            video_on = 1; step();
        end

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            video_on    = ($urandom_range(0, 7) != 0);
            blank_disp  = ($urandom_range(0, 9) == 0);
            hsync_in    = 1'($urandom);
            vsync_in    = 1'($urandom);
            live_pixel  = 12'($urandom);
            region_sel  = 3'($urandom);
            mode        = 2'($urandom);
            pal_wr_en   = ($urandom_range(0, 3) == 0);
            pal_wr_addr = 3'($urandom);
            pal_wr_data = ($urandom_range(0, 4) == 0) ? 12'h000 : 12'($urandom);
            pal_commit  = ($urandom_range(0, 7) == 0);
            frame_start = ($urandom_range(0, 11) == 0);
            step();
        end

        // Reset mid-line with a commit pending
        video_on = 1; blank_disp = 0; region_sel = 0; live_pixel = 12'hFFF;
        hsync_in = 1; vsync_in = 1; mode = 0;
        pal_commit = 1;
        step();
        step();
        step();
        #2 rst_n = 0;
        #1;
        check_eq("midreset_rgb", {red, green, blue}, 12'h000);
        check_eq("midreset_sync", {hsync_out, vsync_out}, 2'b00);
        check_eq("midreset_pend", commit_pending, 1'b0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        idle_inputs();
        video_on = 1; region_sel = 2; live_pixel = 12'h555;
        run(3);
        pal_commit = 1; frame_start = 1;
        run(3);
        region_sel = 1;
        run(3);
        idle_inputs();
        run(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
